// File: rtl/hazard_pkg.sv
// Shared opcode constants, FSM state encoding and opcode-class decode
// helpers for the ID-stage hazard/stall controller.
package hazard_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    function automatic logic is_branch(input logic [5:0] op);
        return (op == OP_BEQ) || (op == OP_BNE);
    endfunction

    function automatic logic is_jump(input logic [5:0] op);
        return (op == OP_J) || (op == OP_JAL);
    endfunction

    function automatic logic is_lw(input logic [5:0] op);
        return op == OP_LW;
    endfunction

    // $zero is never a real dependency, so a zero source never matches.
    function automatic logic src_match(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic use_rt, input logic [4:0] rd);
        return ((rs != 5'd0) && (rs == rd)) ||
               (use_rt && (rt != 5'd0) && (rt == rd));
    endfunction

    function automatic logic [1:0] max_bub(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ID-stage hazard unit: turns load-use / branch-operand hazards into counted
// bubble bursts, freezes on memory wait, flushes IF on taken branch/jump.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int LD_USE_BUB = 2,
    parameter int BR_ALU_BUB = 1,
    parameter int BR_LD_BUB  = 2,
    parameter int HOLDOFF    = 1,
    parameter int CNT_W      = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             id_valid,
    input  logic [5:0]       id_opcode,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [5:0]       ex_opcode,
    input  logic             ex_regwrite,
    input  logic [4:0]       ex_rd,
    input  logic [5:0]       mem_opcode,
    input  logic             mem_regwrite,
    input  logic [4:0]       mem_rd,
    input  logic             branch_taken,
    input  logic [1:0]       jump,
    input  logic             mem_busy,
    input  logic             cnt_clr,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             if_flush,
    output logic             hazard_ctrl,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             busy
);

    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;

    localparam logic [1:0] LD_USE_N  = 2'(LD_USE_BUB);
    localparam logic [1:0] LD_USE_M1 = 2'((LD_USE_BUB > 0) ? LD_USE_BUB - 1 : 0);
    localparam logic [1:0] BR_ALU_N  = 2'(BR_ALU_BUB);
    localparam logic [1:0] BR_LD_N   = 2'(BR_LD_BUB);
    localparam logic [1:0] BR_LD_M1  = 2'((BR_LD_BUB > 0) ? BR_LD_BUB - 1 : 0);

    state_t        state, state_n;
    logic [1:0]    bub_cnt, bub_n;
    logic [HW-1:0] hold_cnt, hold_n;
    logic [1:0]    need;

    logic id_br, id_jmp, use_rt;
    logic ex_ld, mem_ld, ex_alu;
    logic m_ex, m_mem;

    always_comb begin
        id_br  = is_branch(id_opcode);
        id_jmp = is_jump(id_opcode);
        use_rt = id_br || (id_opcode == OP_RTYPE);
        ex_ld  = ex_regwrite && is_lw(ex_opcode);
        mem_ld = mem_regwrite && is_lw(mem_opcode);
        ex_alu = ex_regwrite && !is_lw(ex_opcode) && !is_branch(ex_opcode)
                 && !is_jump(ex_opcode);
        m_ex   = src_match(id_rs, id_rt, use_rt, ex_rd);
        m_mem  = src_match(id_rs, id_rt, use_rt, mem_rd);
    end

    // Worst-case bubble depth over every producer/consumer pairing that applies.
    always_comb begin
        need = 2'd0;
        if (!RESET && (state == RUN) && id_valid && !mem_busy) begin
            if (id_br) begin
                if (ex_ld && m_ex)   need = max_bub(need, BR_LD_N);
                if (mem_ld && m_mem) need = max_bub(need, BR_LD_M1);
                if (ex_alu && m_ex)  need = max_bub(need, BR_ALU_N);
            end else if (!id_jmp) begin
                if (ex_ld && m_ex)   need = max_bub(need, LD_USE_N);
                if (mem_ld && m_mem) need = max_bub(need, LD_USE_M1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= HOLD;
            bub_cnt  <= 2'd0;
            hold_cnt <= HW'(HOLDOFF);
        end else begin
            state    <= state_n;
            bub_cnt  <= bub_n;
            hold_cnt <= hold_n;
        end
    end

    always_comb begin
        state_n     = state;
        bub_n       = bub_cnt;
        hold_n      = hold_cnt;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        if_flush    = 1'b0;
        hazard_ctrl = 1'b0;
        if (!RESET) begin
            case (state)
                HOLD: begin
                    if (hold_cnt != '0) hold_n = hold_cnt - HW'(1);
                    if (hold_cnt <= HW'(1)) state_n = RUN;
                end
                RUN: begin
                    if (mem_busy) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                    end else if (need != 2'd0) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        hazard_ctrl = 1'b1;
                        bub_n       = need - 2'd1;
                        if (need > 2'd1) state_n = STALL;
                    end else if (branch_taken || (jump != 2'b00)) begin
                        if_flush = 1'b1;
                    end
                end
                STALL: begin
                    if (mem_busy) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                    end else begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        hazard_ctrl = 1'b1;
                        bub_n       = bub_cnt - 2'd1;
                        if (bub_cnt <= 2'd1) state_n = RUN;
                    end
                end
                default: state_n = HOLD;
            endcase
        end
    end

    assign busy = (state != RUN) || mem_busy;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (CLK),
        .clr (RESET | cnt_clr),
        .inc (hazard_ctrl),
        .q   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (CLK),
        .clr (RESET | cnt_clr),
        .inc (if_flush),
        .q   (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: a default-width instance and a
// 4-bit-counter instance driven by identical stimulus.
module tb_hazard_stall_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        id_valid;
    logic [5:0]  id_opcode;
    logic [4:0]  id_rs, id_rt;
    logic [5:0]  ex_opcode;
    logic        ex_regwrite;
    logic [4:0]  ex_rd;
    logic [5:0]  mem_opcode;
    logic        mem_regwrite;
    logic [4:0]  mem_rd;
    logic        branch_taken;
    logic [1:0]  jump;
    logic        mem_busy;
    logic        cnt_clr;

    logic        pc_write, ifid_write, if_flush, hazard_ctrl, busy;
    logic [15:0] stall_cnt, flush_cnt;
    logic        pc_write4, ifid_write4, if_flush4, hazard_ctrl4, busy4;
    logic [3:0]  stall_cnt4, flush_cnt4;

    int checks = 0;
    int errors = 0;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000;

    always #5 CLK = ~CLK;

    hazard_stall_ctrl dut (
        .CLK(CLK), .RESET(RESET), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .ex_opcode(ex_opcode), .ex_regwrite(ex_regwrite),
        .ex_rd(ex_rd), .mem_opcode(mem_opcode), .mem_regwrite(mem_regwrite),
        .mem_rd(mem_rd), .branch_taken(branch_taken), .jump(jump), .mem_busy(mem_busy),
        .cnt_clr(cnt_clr), .pc_write(pc_write), .ifid_write(ifid_write),
        .if_flush(if_flush), .hazard_ctrl(hazard_ctrl), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt), .busy(busy)
    );

    hazard_stall_ctrl #(.CNT_W(4)) dut4 (
        .CLK(CLK), .RESET(RESET), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .ex_opcode(ex_opcode), .ex_regwrite(ex_regwrite),
        .ex_rd(ex_rd), .mem_opcode(mem_opcode), .mem_regwrite(mem_regwrite),
        .mem_rd(mem_rd), .branch_taken(branch_taken), .jump(jump), .mem_busy(mem_busy),
        .cnt_clr(cnt_clr), .pc_write(pc_write4), .ifid_write(ifid_write4),
        .if_flush(if_flush4), .hazard_ctrl(hazard_ctrl4), .stall_cnt(stall_cnt4),
        .flush_cnt(flush_cnt4), .busy(busy4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #2;
    endtask

    task automatic clear_pipe();
        id_valid = 1'b0; id_opcode = '0; id_rs = '0; id_rt = '0;
        ex_opcode = '0; ex_regwrite = 1'b0; ex_rd = '0;
        mem_opcode = '0; mem_regwrite = 1'b0; mem_rd = '0;
        branch_taken = 1'b0; jump = '0;
    endtask

    task automatic ld_use_r8();
        id_valid = 1'b1; id_opcode = '0; id_rs = 5'd8; id_rt = 5'd0;
        ex_opcode = LW; ex_regwrite = 1'b1; ex_rd = 5'd8;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        clear_pipe();
        mem_busy = 1'b0; cnt_clr = 1'b0;
        RESET = 1'b1;
        ld_use_r8();
        cyc();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rst_pc_write", pc_write, 1);
            chk("rst_ifid_write", ifid_write, 1);
            chk("rst_hazard", hazard_ctrl, 0);
            chk("rst_stall_cnt", stall_cnt, 0);
            chk("rst_flush_cnt", flush_cnt, 0);
            cyc();
        end

        RESET = 1'b0;
        #1;
        chk("hold_pc_write", pc_write, 1);
        chk("hold_hazard", hazard_ctrl, 0);
        chk("hold_busy", busy, 1);
        cyc();

        // lw r8 in EX, add using r8 in ID: two bubbles
        #1;
        chk("lu1_hazard", hazard_ctrl, 1);
        chk("lu1_pc_write", pc_write, 0);
        chk("lu1_ifid_write", ifid_write, 0);
        chk("lu1_busy", busy, 0);
        cyc();
        ex_opcode = '0; ex_regwrite = 1'b0; ex_rd = '0;
        mem_opcode = LW; mem_regwrite = 1'b1; mem_rd = 5'd8;
        #1;
        chk("lu2_hazard", hazard_ctrl, 1);
        chk("lu2_pc_write", pc_write, 0);
        chk("lu2_stall_cnt", stall_cnt, 1);
        chk("lu2_busy", busy, 1);
        cyc();
        mem_opcode = '0; mem_regwrite = 1'b0; mem_rd = '0;
        #1;
        chk("lu3_hazard", hazard_ctrl, 0);
        chk("lu3_pc_write", pc_write, 1);
        chk("lu3_stall_cnt", stall_cnt, 2);
        chk("lu3_busy", busy, 0);
        cyc();

        // lw in MEM feeding rt of an R-type: one bubble
        id_rs = 5'd3; id_rt = 5'd8;
        mem_opcode = LW; mem_regwrite = 1'b1; mem_rd = 5'd8;
        #1;
        chk("memlw_hazard", hazard_ctrl, 1);
        chk("memlw_ifid", ifid_write, 0);
        cyc();
        clear_pipe();
        #1;
        chk("memlw_done", hazard_ctrl, 0);
        chk("memlw_stall_cnt", stall_cnt, 3);
        cyc();

        // I-type consumer compares rs only
        id_valid = 1'b1; id_opcode = ADDI; id_rs = 5'd3; id_rt = 5'd8;
        ex_opcode = LW; ex_regwrite = 1'b1; ex_rd = 5'd8;
        #1;
        chk("itype_rt_ignored", hazard_ctrl, 0);
        chk("itype_pc_write", pc_write, 1);
        cyc();

        // $zero never matches
        id_opcode = '0; id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
        #1;
        chk("zero_hazard", hazard_ctrl, 0);
        chk("zero_pc_write", pc_write, 1);
        cyc();

        // beq on ALU result: one bubble, flush deferred to next cycle
        clear_pipe();
        id_valid = 1'b1; id_opcode = BEQ; id_rs = 5'd9;
        ex_opcode = '0; ex_regwrite = 1'b1; ex_rd = 5'd9;
        branch_taken = 1'b1;
        #1;
        chk("br_hazard", hazard_ctrl, 1);
        chk("br_no_flush", if_flush, 0);
        chk("br_pc_write", pc_write, 0);
        cyc();
        ex_regwrite = 1'b0; ex_rd = '0;
        #1;
        chk("br_flush", if_flush, 1);
        chk("br_hazard_off", hazard_ctrl, 0);
        chk("br_stall_cnt", stall_cnt, 4);
        chk("br_flush_cnt0", flush_cnt, 0);
        cyc();
        clear_pipe();
        #1;
        chk("br_flush_off", if_flush, 0);
        chk("br_flush_cnt1", flush_cnt, 1);

        // freeze wins over flush
        branch_taken = 1'b1; mem_busy = 1'b1;
        #1;
        chk("frz_flush", if_flush, 0);
        chk("frz_pc_write", pc_write, 0);
        chk("frz_ifid", ifid_write, 0);
        chk("frz_busy", busy, 1);
        cyc();
        #1;
        chk("frz_flush_cnt", flush_cnt, 1);
        mem_busy = 1'b0; branch_taken = 1'b0;

        // freeze in the middle of a lw-use stall
        ld_use_r8();
        #1;
        chk("fs_first_bubble", hazard_ctrl, 1);
        cyc();
        mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("fs_hazard", hazard_ctrl, 0);
            chk("fs_pc_write", pc_write, 0);
            chk("fs_busy", busy, 1);
            cyc();
        end
        #1;
        chk("fs_stall_hold", stall_cnt, 5);
        mem_busy = 1'b0;
        #1;
        chk("fs_resume", hazard_ctrl, 1);
        chk("fs_resume_pc", pc_write, 0);
        cyc();
        clear_pipe();
        #1;
        chk("fs_done", hazard_ctrl, 0);
        chk("fs_pc_write_done", pc_write, 1);
        chk("fs_stall_cnt", stall_cnt, 6);
        chk("fs_busy_done", busy, 0);
        cyc();

        // saturation on 4-bit instance, then clear
        cnt_clr = 1'b1;
        cyc();
        #1;
        chk("clr_stall", stall_cnt, 0);
        chk("clr_flush", flush_cnt, 0);
        chk("clr_stall4", stall_cnt4, 0);
        cnt_clr = 1'b0;
        ld_use_r8();
        repeat (20) cyc();
        #1;
        chk("sat_stall16", stall_cnt, 20);
        chk("sat_stall4", stall_cnt4, 15);
        chk("sat_hazard", hazard_ctrl, 1);
        cnt_clr = 1'b1;
        clear_pipe();
        cyc();
        #1;
        chk("sat_clr4", stall_cnt4, 0);
        chk("sat_clr16", stall_cnt, 0);
        cnt_clr = 1'b0;

        // reset aborts a stall immediately
        ld_use_r8();
        #1;
        chk("rs_bubble", hazard_ctrl, 1);
        cyc();
        RESET = 1'b1;
        #1;
        chk("rs_abort_hazard", hazard_ctrl, 0);
        chk("rs_abort_pc", pc_write, 1);
        cyc();
        RESET = 1'b0;
        #1;
        chk("rs_hold_hazard", hazard_ctrl, 0);
        chk("rs_hold_busy", busy, 1);
        cyc();
        #1;
        chk("rs_run_hazard", hazard_ctrl, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Parametrised successor to the pipeline hazard detection unit for the 5-stage MIPS core.
- Detects load-use and branch-operand hazards and converts each into a counted burst of N bubbles. Bubble depths are parameters, so they are not fixed by re-evaluating stage opcodes every cycle.
- Adds a memory-wait freeze (cache/memory busy), a post-reset holdoff, $zero filtering, and saturating stall/flush performance counters.
- Sits in the ID stage; drives PC enable, IF/ID enable, IF flush and the ID/EX bubble mux.

Parameters:
LD_USE_BUB, 2, bubbles for lw in EX feeding a non-branch consumer in ID (range 0..3)
BR_ALU_BUB, 1, bubbles for an ALU result in EX feeding a beq/bne in ID (range 0..3)
BR_LD_BUB, 2, bubbles for lw in EX feeding a beq/bne in ID (range 0..3)
HOLDOFF, 1, cycles after reset release during which no hazards are raised
CNT_W, 16, width of the performance counters

Ports:
CLK  in  1  clock
RESET  in  1  synchronous active-high reset
id_valid  in  1  ID holds a real instruction
id_opcode  in  6  ID opcode
id_rs  in  5  ID source register rs
id_rt  in  5  ID source register rt
ex_opcode  in  6  EX opcode
ex_regwrite  in  1  EX writes the register file
ex_rd  in  5  EX destination register
mem_opcode  in  6  MEM opcode
mem_regwrite  in  1  MEM writes the register file
mem_rd  in  5  MEM destination register
branch_taken  in  1  branch resolved taken in ID
jump  in  2  jump type; nonzero means a jump
mem_busy  in  1  memory/cache not ready; freeze the pipeline
cnt_clr  in  1  clear the performance counters
pc_write  out  1  PC update enable
ifid_write  out  1  IF/ID register enable
if_flush  out  1  flush IF/ID
hazard_ctrl  out  1  zero the ID/EX control signals (bubble)
stall_cnt  out  CNT_W  bubbles inserted (saturating)
flush_cnt  out  CNT_W  flushes issued (saturating)
busy  out  1  FSM not in RUN

Behaviour:
- Reset (synchronous, RESET=1 at the CLK edge):
  - FSM goes to HOLD; bubble counter = 0; holdoff counter = HOLDOFF; both perf counters = 0.
  - During reset and HOLD, outputs are pc_write=1, ifid_write=1, if_flush=0, hazard_ctrl=0.
  - A reset mid-stall or mid-freeze aborts it immediately.
- HOLD: decrement the holdoff counter each cycle; go to RUN when it reaches 0. If HOLDOFF=0, go straight to RUN.
- Opcode classes: lw=100011, branch=000100/000101, R-type=000000, jump=000010/000011.
- Hazard match: a source register matches only if it is nonzero and equals the producer's rd. For non-branch, non-R-type consumers only rs is compared; otherwise rs and rt are compared.
- Required bubble count need, evaluated in RUN only, when id_valid=1 and mem_busy=0. Take the maximum over the applicable cases:
  - Branch in ID, lw in EX, match: BR_LD_BUB.
  - Branch in ID, lw in MEM, match: BR_LD_BUB-1.
  - Branch in ID, EX has regwrite, is not lw/branch/jump, match: BR_ALU_BUB.
  - Non-branch, non-jump in ID, lw in EX, match: LD_USE_BUB.
  - Non-branch, non-jump in ID, lw in MEM, match: LD_USE_BUB-1.
  - Values <= 0 mean no stall.
- RUN, need >= 1: this cycle assert pc_write=0, ifid_write=0, hazard_ctrl=1. Load the bubble counter with need-1. If need-1 > 0, go to STALL.
- STALL:
  - Each cycle assert the same three stall outputs and decrement the counter.
  - Leave for RUN in the cycle the counter reads 1. The next cycle re-evaluates from scratch.
- Freeze (any state except reset/HOLD, mem_busy=1):
  - pc_write=0, ifid_write=0, hazard_ctrl=0, if_flush=0.
  - Bubble counter holds; busy=1; no counter increments.
  - mem_busy has priority over hazard detection and over flush.
- Flush: if_flush=1 only in RUN, with need=0, mem_busy=0, and (branch_taken or jump!=0). A flush is therefore suppressed during any stall.
- Counters: stall_cnt += 1 per cycle with hazard_ctrl=1; flush_cnt += 1 per cycle with if_flush=1. Both saturate at all-ones. cnt_clr zeroes both next cycle, with priority over increment.
- busy = (state != RUN) or mem_busy.
- All control outputs are combinational from the state and current inputs; the counters are registered.

Decomposition:
- Shared package hazard_pkg holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL;
  - state encoding: HOLD, RUN, STALL;
  - class-decode functions: is_branch, is_jump, is_lw.
- One sub-module, sat_counter (parameter W; ports inc, clr, q), instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- Reset, then hold RESET=1 for 3 cycles -> pc_write=1, ifid_write=1, hazard_ctrl=0, stall_cnt=0, flush_cnt=0; one HOLD cycle, then RUN.
- ID add rs=8, EX lw rd=8 (defaults) -> hazard_ctrl=1 for exactly 2 cycles, pc_write=0 for both, stall_cnt=2.
- ID beq rs=9, EX add rd=9 regwrite, branch_taken=1 -> 1 bubble with if_flush=0; next cycle (EX now bubble) if_flush=1, flush_cnt=1.
- ID add rs=0, EX lw rd=0 -> no stall: pc_write=1, hazard_ctrl=0.
- lw-use stall in progress, counter=1, mem_busy=1 for 4 cycles -> hazard_ctrl=0 and pc_write=0 during the freeze; 1 bubble resumes after mem_busy drops; total stall_cnt=2.
- CNT_W=4, force 20 stall cycles -> stall_cnt saturates at 15; cnt_clr=1 -> 0 next cycle.
